ir_burst_engine: RTL and testbench

Parametrised successor to the single-LED TV-B-Gone player. It walks a byte-wide code table and generates modulated IR bursts on up to 8 LED channels, with a per-record channel mask. Carrier generation, mark/space timing, inter-code gap, abort and loop control all live inside this one block. It sits between the start-button debouncer and the IR LED drivers, and reads a combinational code ROM.

---
 rtl/ir_burst_engine.sv | 252 +++++++++++++++++++++++++
 tb/tb_ir_burst_engine.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_burst_engine.sv
// rtl/ir_burst_engine.sv - table-driven multi-channel IR burst generator
module ir_burst_engine #(
    parameter int CHANNELS    = 1,
    parameter int ADDR_WIDTH  = 13,
    parameter int DELAY_BYTES = 2,
    parameter int PRESCALE    = 16,
    parameter int GAP_UNITS   = 1000
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic                  loop_forever_in,
    output logic [ADDR_WIDTH-1:0] mem_address_out,
    input  logic [7:0]            mem_data_in,
    output logic [CHANNELS-1:0]   ir_out,
    output logic                  busy_out,
    output logic                  fail_out,
    output logic [15:0]           codes_sent_out
);

    localparam int DW = 8 * DELAY_BYTES;
    localparam int GW = $clog2(GAP_UNITS + 1);
    localparam int UW = (GW > DW) ? GW : DW;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_CARRIER, S_HDR_MASK, S_HDR_COUNT, S_LOAD_ON,
        S_MARK, S_LOAD_OFF, S_SPACE, S_GAP, S_DONE, S_FAIL
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            hp_q, hp_d;
    logic [CHANNELS-1:0]   mask_q, mask_d;
    logic [7:0]            pair_q, pair_d;
    logic [1:0]            byte_q, byte_d;
    logic [DW-1:0]         dly_q, dly_d;
    logic [UW-1:0]         unit_q, unit_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic [7:0]            car_cnt_q, car_cnt_d;
    logic                  car_ph_q, car_ph_d;
    logic [15:0]           codes_q, codes_d;
    logic                  fail_q, fail_d;
    logic                  busy_q, busy_d;
    logic [CHANNELS-1:0]   ir_q, ir_d;
    logic                  start_prev_q;

    logic                  start_edge, pre_wrap, timer_done, byte_last, at_top;
    logic                  read_state, finish_pair, enter_timed;
    logic [UW-1:0]         enter_units;
    logic [DW-1:0]         rd_full;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        hp_d        = hp_q;
        mask_d      = mask_q;
        pair_d      = pair_q;
        byte_d      = byte_q;
        dly_d       = dly_q;
        unit_d      = unit_q;
        pre_d       = pre_q;
        car_cnt_d   = car_cnt_q;
        car_ph_d    = car_ph_q;
        codes_d     = codes_q;
        fail_d      = fail_q;
        ir_d        = '0;
        read_state  = 1'b0;
        finish_pair = 1'b0;
        enter_timed = 1'b0;
        enter_units = '0;

        start_edge = start_in & ~start_prev_q;
        rd_full    = (dly_q << 8) | DW'(mem_data_in);
        pre_wrap   = (pre_q == PW'(PRESCALE - 1));
        timer_done = pre_wrap && (unit_q == UW'(1));
        byte_last  = (byte_q == 2'(DELAY_BYTES - 1));
        at_top     = &addr_q;

        if (state_q == S_MARK || state_q == S_SPACE || state_q == S_GAP) begin
            if (pre_wrap) begin
                pre_d  = '0;
                unit_d = unit_q - UW'(1);
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_edge) begin
                    state_d = S_HDR_CARRIER;
                    addr_d  = '0;
                    fail_d  = 1'b0;
                    codes_d = '0;
                end
            end
            S_HDR_CARRIER: begin
                read_state = 1'b1;
                addr_d     = addr_q + 1'b1;
                hp_d       = mem_data_in;
                if (mem_data_in == 8'd0) begin
                    if (loop_forever_in) begin
                        addr_d  = '0;
                        state_d = S_HDR_CARRIER;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_HDR_MASK;
                end
            end
            S_HDR_MASK: begin
                read_state = 1'b1;
                addr_d     = addr_q + 1'b1;
                mask_d     = mem_data_in[CHANNELS-1:0];
                state_d    = S_HDR_COUNT;
            end
            S_HDR_COUNT: begin
                read_state = 1'b1;
                addr_d     = addr_q + 1'b1;
                pair_d     = mem_data_in;
                byte_d     = '0;
                state_d    = (mem_data_in == 8'd0) ? S_FAIL : S_LOAD_ON;
            end
            S_LOAD_ON, S_LOAD_OFF: begin
                read_state = 1'b1;
                addr_d     = addr_q + 1'b1;
                dly_d      = rd_full;
                byte_d     = byte_q + 2'd1;
                if (byte_last) begin
                    byte_d = '0;
                    // A zero duration skips its timed state entirely.
                    if (rd_full == '0) begin
                        if (state_q == S_LOAD_ON) state_d = S_LOAD_OFF;
                        else                      finish_pair = 1'b1;
                    end else begin
                        state_d     = (state_q == S_LOAD_ON) ? S_MARK : S_SPACE;
                        enter_timed = 1'b1;
                        enter_units = UW'(rd_full);
                    end
                end
            end
            S_MARK: begin
                ir_d = mask_q & {CHANNELS{car_ph_q}};
                if (car_cnt_q + 8'd1 == hp_q) begin
                    car_cnt_d = '0;
                    car_ph_d  = ~car_ph_q;
                end else begin
                    car_cnt_d = car_cnt_q + 8'd1;
                end
                if (timer_done) begin
                    state_d = S_LOAD_OFF;
                    byte_d  = '0;
                end
            end
            S_SPACE: begin
                if (timer_done) finish_pair = 1'b1;
            end
            S_GAP: begin
                if (timer_done) state_d = S_HDR_CARRIER;
            end
            default: state_d = S_IDLE;
        endcase

        if (finish_pair) begin
            if (pair_q == 8'd1) begin
                codes_d     = codes_q + 16'd1;
                state_d     = S_GAP;
                enter_timed = 1'b1;
                enter_units = UW'(GAP_UNITS);
            end else begin
                pair_d  = pair_q - 8'd1;
                byte_d  = '0;
                state_d = S_LOAD_ON;
            end
        end

        if (enter_timed) begin
            pre_d     = '0;
            car_cnt_d = '0;
            car_ph_d  = 1'b1;
            unit_d    = enter_units;
        end

        // The last ROM byte may only be the single-byte end marker.
        if (read_state && at_top && !(state_q == S_HDR_CARRIER && mem_data_in == 8'd0))
            state_d = S_FAIL;

        if (state_d == S_FAIL) fail_d = 1'b1;

        if (abort_in && state_q != S_IDLE) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            codes_d = codes_q;
            fail_d  = fail_q;
        end else if (abort_in) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            codes_d = codes_q;
            fail_d  = fail_q;
        end

        busy_d = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_FAIL);
    end

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            hp_q         <= '0;
            mask_q       <= '0;
            pair_q       <= '0;
            byte_q       <= '0;
            dly_q        <= '0;
            unit_q       <= '0;
            pre_q        <= '0;
            car_cnt_q    <= '0;
            car_ph_q     <= 1'b0;
            codes_q      <= '0;
            fail_q       <= 1'b0;
            busy_q       <= 1'b0;
            ir_q         <= '0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hp_q         <= hp_d;
            mask_q       <= mask_d;
            pair_q       <= pair_d;
            byte_q       <= byte_d;
            dly_q        <= dly_d;
            unit_q       <= unit_d;
            pre_q        <= pre_d;
            car_cnt_q    <= car_cnt_d;
            car_ph_q     <= car_ph_d;
            codes_q      <= codes_d;
            fail_q       <= fail_d;
            busy_q       <= busy_d;
            ir_q         <= ir_d;
            start_prev_q <= start_in;
        end
    end

    assign mem_address_out = addr_q;
    assign ir_out          = ir_q;
    assign busy_out        = busy_q;
    assign fail_out        = fail_q;
    assign codes_sent_out  = codes_q;

endmodule

// File: tb/tb_ir_burst_engine.sv
// tb/tb_ir_burst_engine.sv - directed self-checking bench for ir_burst_engine
module tb_ir_burst_engine;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          loop_f = 1'b0;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [1:0]    ir;
    logic          busy;
    logic          fail;
    logic [15:0]   codes;
    logic [7:0]    rom [0:63];
    int            checks = 0;
    int            errors = 0;

    assign data = rom[addr];

    always #5 clk = ~clk;

    ir_burst_engine #(
        .CHANNELS(2), .ADDR_WIDTH(AW), .DELAY_BYTES(2), .PRESCALE(2), .GAP_UNITS(5)
    ) dut (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(start), .abort_in(abort),
        .loop_forever_in(loop_f), .mem_address_out(addr), .mem_data_in(data),
        .ir_out(ir), .busy_out(busy), .fail_out(fail), .codes_sent_out(codes)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
    endtask

    task automatic put_record(input int base, input logic [7:0] hp, input logic [7:0] mask,
                              input logic [15:0] on_t, input logic [15:0] off_t);
        rom[base]   = hp;
        rom[base+1] = mask;
        rom[base+2] = 8'd1;
        rom[base+3] = on_t[15:8];
        rom[base+4] = on_t[7:0];
        rom[base+5] = off_t[15:8];
        rom[base+6] = off_t[7:0];
    endtask

    // Leaves the bench at the negedge just after the start edge (s = 0).
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        int n = 0;
        while (busy === 1'b1 && n < bound) begin tick(); n++; end
        ok = (busy === 1'b0);
    endtask

    task automatic wait_codes(input int target, input int bound, output bit ok);
        int n = 0;
        while (codes !== 16'(target) && n < bound) begin tick(); n++; end
        ok = (codes === 16'(target));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({ir, busy, fail, addr, codes} !== '0) begin
            errors++;
            $display("FAIL reset_state got ir=%b busy=%b fail=%b addr=%0d codes=%0d expected all 0",
                     ir, busy, fail, addr, codes);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_record();
        logic e;
        clear_rom();
        put_record(0, 8'd3, 8'h01, 16'd4, 16'd2);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || addr !== '0) begin
            errors++;
            $display("FAIL single_start got busy=%b addr=%0d expected busy=1 addr=0", busy, addr);
        end
        for (int s = 1; s <= 31; s++) begin
            tick();
            e = (s >= 6 && s <= 8) || s == 12 || s == 13;
            checks++;
            if (ir !== {1'b0, e}) begin
                errors++;
                $display("FAIL single_ir s=%0d got %b expected %b", s, ir, {1'b0, e});
            end
            checks++;
            if (busy !== (s <= 29)) begin
                errors++;
                $display("FAIL single_busy s=%0d got %b expected %b", s, busy, (s <= 29));
            end
        end
        checks++;
        if (codes !== 16'd1 || fail !== 1'b0) begin
            errors++;
            $display("FAIL single_done got codes=%0d fail=%b expected codes=1 fail=0", codes, fail);
        end
    endtask

    task automatic test_channel_mask();
        logic e;
        clear_rom();
        put_record(0, 8'd3, 8'h02, 16'd4, 16'd2);
        pulse_start();
        for (int s = 1; s <= 31; s++) begin
            tick();
            e = (s >= 6 && s <= 8) || s == 12 || s == 13;
            checks++;
            if (ir !== {e, 1'b0}) begin
                errors++;
                $display("FAIL mask_ir s=%0d got %b expected %b", s, ir, {e, 1'b0});
            end
        end
    endtask

    task automatic test_pair_count_zero();
        bit ok;
        clear_rom();
        put_record(0, 8'd3, 8'h01, 16'd1, 16'd1);
        rom[7] = 8'd3; rom[8] = 8'h01; rom[9] = 8'd0;
        pulse_start();
        wait_idle(200, ok);
        checks++;
        if (!ok || fail !== 1'b1 || codes !== 16'd1 || ir !== 2'b00) begin
            errors++;
            $display("FAIL n0_fail got busy=%b fail=%b codes=%0d ir=%b expected busy=0 fail=1 codes=1 ir=00",
                     busy, fail, codes, ir);
        end
        pulse_abort();
        checks++;
        if (fail !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL n0_abort_keeps_fail got fail=%b busy=%b expected fail=1 busy=0", fail, busy);
        end
        pulse_start();
        checks++;
        if (fail !== 1'b0 || busy !== 1'b1 || codes !== 16'd0) begin
            errors++;
            $display("FAIL n0_restart got fail=%b busy=%b codes=%0d expected fail=0 busy=1 codes=0",
                     fail, busy, codes);
        end
        pulse_abort();
    endtask

    task automatic test_loop_forever();
        bit ok;
        clear_rom();
        put_record(0, 8'd2, 8'h01, 16'd1, 16'd1);
        put_record(7, 8'd2, 8'h01, 16'd1, 16'd1);
        loop_f = 1'b1;
        pulse_start();
        wait_codes(2, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL loop_codes2 got codes=%0d expected 2", codes);
        end
        begin
            int n = 0;
            while (addr !== '0 && n < 100) begin tick(); n++; end
        end
        checks++;
        if (addr !== '0 || codes !== 16'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_wrap got addr=%0d codes=%0d busy=%b expected addr=0 codes=2 busy=1",
                     addr, codes, busy);
        end
        wait_codes(4, 300, ok);
        checks++;
        if (!ok || busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_codes4 got codes=%0d busy=%b expected codes=4 busy=1", codes, busy);
        end
        pulse_abort();
        loop_f = 1'b0;
        checks++;
        if (busy !== 1'b0 || codes !== 16'd4) begin
            errors++;
            $display("FAIL loop_abort got busy=%b codes=%0d expected busy=0 codes=4", busy, codes);
        end
    endtask

    task automatic test_abort_mark();
        clear_rom();
        put_record(0, 8'd3, 8'h01, 16'd20, 16'd2);
        pulse_start();
        repeat (8) tick();
        checks++;
        if (ir !== 2'b01) begin
            errors++;
            $display("FAIL abort_in_mark got ir=%b expected 01", ir);
        end
        pulse_abort();
        checks++;
        if (busy !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got busy=%b fail=%b expected busy=0 fail=0", busy, fail);
        end
        tick();
        checks++;
        if (ir !== 2'b00) begin
            errors++;
            $display("FAIL abort_ir got ir=%b expected 00", ir);
        end
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_with_abort got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_space();
        bit ok;
        clear_rom();
        put_record(0, 8'd3, 8'h01, 16'd1, 16'd1);
        put_record(7, 8'd3, 8'h01, 16'd1, 16'd1);
        pulse_start();
        wait_codes(1, 200, ok);
        repeat (19) tick();
        checks++;
        if (!ok || busy !== 1'b1 || addr !== 6'd14) begin
            errors++;
            $display("FAIL pre_reset_space got busy=%b addr=%0d expected busy=1 addr=14", busy, addr);
        end
        rst_n = 1'b0; abort = 1'b1;
        tick();
        checks++;
        if ({ir, busy, fail, addr, codes} !== '0) begin
            errors++;
            $display("FAIL reset_mid_space got ir=%b busy=%b fail=%b addr=%0d codes=%0d expected all 0",
                     ir, busy, fail, addr, codes);
        end
        rst_n = 1'b1; abort = 1'b0;
        tick();
    endtask

    task automatic test_on_time_zero();
        int ir_high = 0;
        clear_rom();
        put_record(0, 8'd3, 8'h01, 16'd0, 16'd3);
        pulse_start();
        for (int s = 1; s <= 26; s++) begin
            tick();
            if (ir !== 2'b00) ir_high++;
            if (s == 23) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL on0_busy_s23 got %b expected 1", busy);
                end
            end
            if (s == 24) begin
                checks++;
                if (busy !== 1'b0 || codes !== 16'd1) begin
                    errors++;
                    $display("FAIL on0_done_s24 got busy=%b codes=%0d expected busy=0 codes=1", busy, codes);
                end
            end
        end
        checks++;
        if (ir_high != 0) begin
            errors++;
            $display("FAIL on0_no_mark got %0d active cycles expected 0", ir_high);
        end
    endtask

    task automatic test_carrier_255();
        int hi = 0;
        int lo = 0;
        clear_rom();
        put_record(0, 8'd255, 8'h01, 16'd400, 16'd1);
        pulse_start();
        repeat (5) tick();
        checks++;
        if (ir !== 2'b00) begin
            errors++;
            $display("FAIL hp255_pre got ir=%b expected 00", ir);
        end
        tick();
        while (ir[0] === 1'b1 && hi < 600) begin hi++; tick(); end
        while (ir[0] === 1'b0 && lo < 600) begin lo++; tick(); end
        checks++;
        if (hi != 255 || lo != 255) begin
            errors++;
            $display("FAIL hp255_period got high=%0d low=%0d expected 255 and 255", hi, lo);
        end
        pulse_abort();
    endtask

    task automatic test_addr_overflow();
        bit ok;
        clear_rom();
        rom[0] = 8'd1; rom[1] = 8'h01; rom[2] = 8'd255;
        for (int p = 0; p < 15; p++) rom[3 + 4*p + 3] = 8'd1;
        pulse_start();
        wait_idle(400, ok);
        checks++;
        if (!ok || fail !== 1'b1 || codes !== 16'd0) begin
            errors++;
            $display("FAIL addr_overflow got busy=%b fail=%b codes=%0d expected busy=0 fail=1 codes=0",
                     busy, fail, codes);
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_single_record();
        test_channel_mask();
        test_pair_count_zero();
        test_loop_forever();
        test_abort_mark();
        test_reset_mid_space();
        test_on_time_zero();
        test_carrier_255();
        test_addr_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
